mant_mul_seq: RTL and testbench

//  Sequential controller for the FMUL32 mantissa product stage. Accepts one operand pair
//  per transaction over valid/ready and runs a radix-2 shift-add multiply, one bit per cycle.

---
 rtl/mant_mul_pkg.sv | 28 ++
 rtl/mant_mul_step.sv | 25 ++
 rtl/mant_mul_seq.sv | 93 +++++++++
 tb/tb_mant_mul_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mant_mul_pkg.sv
// Shared types and width helpers for the FMUL32 sequential mantissa multiplier.
package mant_mul_pkg;

    localparam int DEF_DATA_W = 32;

    function automatic int mw_of(input int data_w);
        return data_w - 8;
    endfunction

    function automatic int pw_of(input int data_w);
        return 2 * (data_w - 8);
    endfunction

    function automatic int cnt_w_of(input int data_w);
        return $clog2(data_w - 8);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [1:0] NAN_A  = 2'b10;
    localparam logic [1:0] NAN_B  = 2'b01;
    localparam logic [1:0] NAN_AB = 2'b11;

endpackage

// File: rtl/mant_mul_step.sv
// One radix-2 shift-add iteration: conditionally add A into the upper half of P, then shift right.
module mant_mul_step
    import mant_mul_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    localparam int MW     = mw_of(DATA_W),
    localparam int PW     = pw_of(DATA_W)
) (
    input  logic [PW-1:0] p,
    input  logic [MW-1:0] a,
    output logic [PW-1:0] p_next
);

    logic [MW:0] sum;

    // The extra sum bit is the carry that becomes the new MSB after the shift.
    always_comb begin
        sum = {1'b0, p[PW-1:MW]};
        if (p[0]) begin
            sum = {1'b0, p[PW-1:MW]} + {1'b0, a};
        end
        p_next = {sum, p[MW-1:1]};
    end

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential mantissa product controller: valid/ready in, one shift-add bit per cycle, bypass for NaN/zero.
module mant_mul_seq
    import mant_mul_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    localparam int MW     = mw_of(DATA_W),
    localparam int PW     = pw_of(DATA_W),
    localparam int CNT_W  = cnt_w_of(DATA_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] mant_a,
    input  logic [MW-1:0] mant_b,
    input  logic [1:0]    op_nan,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] prod,
    output logic          busy
);

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [MW-1:0]    a_reg;
    logic [CNT_W-1:0] cnt;
    logic             bypass;
    logic [PW-1:0]    bypass_payload;

    function automatic logic [PW-1:0] nan_payload(input logic [MW-1:0] x);
        return {x[MW-2:0], {(MW+1){1'b0}}};
    endfunction

    mant_mul_step #(.DATA_W(DATA_W)) u_step (
        .p      (acc),
        .a      (a_reg),
        .p_next (acc_next)
    );

    // NaN outranks a zero operand; A's payload wins when both are NaN.
    always_comb begin
        bypass         = (op_nan != 2'b00) || (mant_a == '0) || (mant_b == '0);
        bypass_payload = '0;
        unique case (op_nan)
            NAN_A, NAN_AB: bypass_payload = nan_payload(mant_a);
            NAN_B:         bypass_payload = nan_payload(mant_b);
            default:       bypass_payload = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = bypass ? DONE : CALC;
            CALC:    if (cnt == CNT_W'(MW - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            a_reg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= mant_a;
                        cnt   <= '0;
                        acc   <= bypass ? bypass_payload : {{MW{1'b0}}, mant_b};
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign prod      = acc;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed bench for mant_mul_seq: products, bypass payloads, latency, backpressure and reset abort.
module tb_mant_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic [1:0]  op_nan;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] prod;
    logic        busy;

    int compared;
    int mismatched;

    mant_mul_seq #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_a    (mant_a),
        .mant_b    (mant_b),
        .op_nan    (op_nan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair for a single edge, then scramble the inputs.
    task automatic start_txn(input logic [23:0] a, input logic [23:0] b, input logic [1:0] nan);
        in_valid = 1'b1;
        mant_a   = a;
        mant_b   = b;
        op_nan   = nan;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mant_a   = 24'h5A5A5A;
        mant_b   = 24'h3C3C3C;
        op_nan   = 2'b00;
    endtask

    // The sample right after the accept edge counts as latency 1.
    task automatic wait_valid(output int lat);
        lat = 999;
        for (int i = 1; i <= 60; i++) begin
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_txn();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_a    = '0;
        mant_b    = '0;
        op_nan    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || prod !== 48'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: out_valid=%b busy=%b prod=%h, expected 0 0 0", out_valid, busy, prod);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL idle_out_ready: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_normal();
        logic [23:0] va[3];
        logic [23:0] vb[3];
        logic [47:0] vp[3];
        int lat;
        va = '{24'h800000, 24'hFFFFFF, 24'hC00000};
        vb = '{24'h800000, 24'hFFFFFF, 24'hA00000};
        vp = '{48'h400000000000, 48'hFFFFFE000001, 48'h780000000000};
        for (int i = 0; i < 3; i++) begin
            start_txn(va[i], vb[i], 2'b00);
            compared++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL normal_busy[%0d]: busy=%b in_ready=%b, expected 1 0", i, busy, in_ready);
            end
            wait_valid(lat);
            compared++;
            if (lat !== 25) begin
                mismatched++;
                $display("[TB] FAIL normal_latency[%0d]: got %0d expected 25", i, lat);
            end
            compared++;
            if (prod !== vp[i]) begin
                mismatched++;
                $display("[TB] FAIL normal_prod[%0d]: got %h expected %h", i, prod, vp[i]);
            end
            finish_txn();
        end
    endtask

    task automatic test_bypass();
        logic [23:0] va[6];
        logic [23:0] vb[6];
        logic [1:0]  vn[6];
        logic [47:0] vp[6];
        int lat;
        va = '{24'h400001, 24'h400001, 24'hABCDEF, 24'h000000, 24'h000000, 24'h555555};
        vb = '{24'h123456, 24'hFFFFFF, 24'h000003, 24'hABCDEF, 24'hABCDEF, 24'h000000};
        vn = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00};
        vp = '{48'h800002000000, 48'h800002000000, 48'h000006000000,
               48'h000000000000, 48'h579BDE000000, 48'h000000000000};
        for (int i = 0; i < 6; i++) begin
            start_txn(va[i], vb[i], vn[i]);
            wait_valid(lat);
            compared++;
            if (lat !== 1) begin
                mismatched++;
                $display("[TB] FAIL bypass_latency[%0d]: got %0d expected 1", i, lat);
            end
            compared++;
            if (prod !== vp[i]) begin
                mismatched++;
                $display("[TB] FAIL bypass_prod[%0d]: got %h expected %h", i, prod, vp[i]);
            end
            finish_txn();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_txn(24'hFFFFFF, 24'hFFFFFF, 2'b00);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            mant_a   = 24'h400001;
            mant_b   = 24'h000001;
            op_nan   = 2'b10;
            @(posedge clk);
            #1;
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || prod !== 48'hFFFFFE000001) begin
                mismatched++;
                $display("[TB] FAIL hold_stable[%0d]: out_valid=%b in_ready=%b prod=%h, expected 1 0 fffffe000001",
                         i, out_valid, in_ready, prod);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_idle: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || prod !== 48'h800002000000) begin
            mismatched++;
            $display("[TB] FAIL reaccept: out_valid=%b prod=%h, expected 1 800002000000", out_valid, prod);
        end
        finish_txn();
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        start_txn(24'h800000, 24'h800000, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || prod !== 48'h0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_reset: out_valid=%b prod=%h busy=%b, expected 0 0 0", out_valid, prod, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_abort_idle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        start_txn(24'h800001, 24'h800000, 2'b00);
        wait_valid(lat);
        compared++;
        if (lat !== 25 || prod !== 48'h400000800000) begin
            mismatched++;
            $display("[TB] FAIL post_abort_prod: latency=%0d prod=%h, expected 25 400000800000", lat, prod);
        end
        finish_txn();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_normal();
        test_bypass();
        test_back_to_back();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
